// File: rtl/sfm_pkg.sv
// Shared types and constants for the softmax slot cache (request/update/response payloads,
// per-slot storage record and performance counters).
package sfm_pkg;

    localparam int unsigned SLOT_ADDR_BITS = 8;
    localparam int unsigned WIDTH_IN       = 16;
    localparam int unsigned WIDTH_ACC      = 32;
    localparam int unsigned PERF_W         = 32;

    // fp16 negative infinity: sign 1, exponent all ones, mantissa 0
    localparam logic [WIDTH_IN-1:0] SLOT_NEG_INF_MAX = 16'hFC00;

    typedef enum logic {
        SLOT_OP_ALLOC = 1'b0,
        SLOT_OP_LOAD  = 1'b1
    } slot_req_kind_e;

    typedef enum logic {
        SLOT_OP_UPDATE = 1'b0,
        SLOT_OP_FREE   = 1'b1
    } slot_upd_kind_e;

    typedef struct packed {
        slot_req_kind_e            op;
        logic [SLOT_ADDR_BITS-1:0] addr;
    } slot_req_op_t;

    typedef struct packed {
        slot_upd_kind_e            op;
        logic [SLOT_ADDR_BITS-1:0] addr;
        logic [WIDTH_IN-1:0]       maximum;
        logic [WIDTH_ACC-1:0]      denominator;
    } slot_update_op_t;

    typedef struct packed {
        logic                 valid;
        logic [WIDTH_IN-1:0]  maximum;
        logic [WIDTH_ACC-1:0] denominator;
    } slot_t;

    typedef struct packed {
        logic [SLOT_ADDR_BITS-1:0] addr;
        logic [WIDTH_IN-1:0]       maximum;
        logic [WIDTH_ACC-1:0]      denominator;
        logic                      err;
    } slot_resp_t;

    typedef struct packed {
        logic [PERF_W-1:0] alloc_cnt;
        logic [PERF_W-1:0] alloc_fail_cnt;
        logic [PERF_W-1:0] load_miss_cnt;
    } slot_perf_t;

endpackage

// File: rtl/sfm_slot_free_finder.sv
// Lowest-index free slot finder: combinational priority encoder over the valid vector.
module sfm_slot_free_finder #(
    parameter int unsigned N_SLOTS = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic [N_SLOTS-1:0] valid,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // Scan high to low so the lowest free index wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sfm_slot_cache.sv
// Softmax state cache: N_SLOTS {max, denominator, valid} entries with ALLOC/LOAD requests and
// UPDATE/FREE writes. Define SFM_SLOT_CACHE_PERF_EN to build the saturating perf counters.
module sfm_slot_cache
    import sfm_pkg::*;
#(
    parameter int unsigned N_SLOTS   = 16,
    parameter int unsigned ADDR_W    = sfm_pkg::SLOT_ADDR_BITS,
    parameter int unsigned WIDTH_MAX = sfm_pkg::WIDTH_IN,
    parameter int unsigned WIDTH_DEN = sfm_pkg::WIDTH_ACC
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [ADDR_W:0]                       req_op_i,
    input  logic                                  upd_valid_i,
    input  logic [ADDR_W+WIDTH_MAX+WIDTH_DEN:0]   upd_op_i,
    output logic                                  resp_valid_o,
    input  logic                                  resp_ready_i,
    output logic [ADDR_W+WIDTH_MAX+WIDTH_DEN:0]   resp_o,
    output logic [$clog2(N_SLOTS+1)-1:0]          occupancy_o,
    output logic                                  full_o,
    output logic [3*PERF_W-1:0]                   perf_o
);

    localparam int unsigned IDX_W = $clog2(N_SLOTS);
    localparam int unsigned OCC_W = $clog2(N_SLOTS + 1);

    slot_req_op_t    req_op;
    slot_update_op_t upd_op;
    assign req_op = req_op_i;
    assign upd_op = upd_op_i;

    slot_t              slots_q [N_SLOTS];
    logic [N_SLOTS-1:0] valid_vec;

    slot_resp_t        resp_q;
    slot_resp_t        resp_next;
    logic              resp_valid_q;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_next;
    logic              full_q;

    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  upd_idx;
    logic              req_in_range;
    logic              upd_in_range;
    logic              req_fire;
    logic              alloc_fire;
    logic              alloc_ok;
    logic              upd_live;
    logic              upd_write;
    logic              free_eff;
    logic              same_addr;

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            valid_vec[i] = slots_q[i].valid;
        end
    end

    sfm_slot_free_finder #(
        .N_SLOTS (N_SLOTS),
        .IDX_W   (IDX_W)
    ) u_free_finder (
        .valid (valid_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    assign req_idx      = req_op.addr[IDX_W-1:0];
    assign upd_idx      = upd_op.addr[IDX_W-1:0];
    assign req_in_range = {1'b0, req_op.addr} < (ADDR_W+1)'(N_SLOTS);
    assign upd_in_range = {1'b0, upd_op.addr} < (ADDR_W+1)'(N_SLOTS);

    assign req_ready_o = !resp_valid_q || resp_ready_i;
    assign req_fire    = req_valid_i && req_ready_o;
    assign alloc_fire  = req_fire && (req_op.op == SLOT_OP_ALLOC);
    assign alloc_ok    = alloc_fire && free_found;

    // Update-side decisions all use pre-cycle valid bits.
    assign upd_live  = upd_valid_i && upd_in_range && valid_vec[upd_idx];
    assign upd_write = upd_live && (upd_op.op == SLOT_OP_UPDATE);
    assign free_eff  = upd_live && (upd_op.op == SLOT_OP_FREE);
    assign same_addr = upd_live && (upd_op.addr == req_op.addr);

    // Response for the request presented this cycle, with UPDATE forwarding and FREE kill.
    always_comb begin
        resp_next      = '0;
        resp_next.addr = req_op.addr;
        if (req_op.op == SLOT_OP_ALLOC) begin
            if (free_found) begin
                resp_next.addr    = ADDR_W'(free_idx);
                resp_next.maximum = SLOT_NEG_INF_MAX;
            end else begin
                resp_next.addr = '0;
                resp_next.err  = 1'b1;
            end
        end else if (req_in_range && valid_vec[req_idx] && !(same_addr && free_eff)) begin
            if (same_addr && upd_write) begin
                resp_next.maximum     = upd_op.maximum;
                resp_next.denominator = upd_op.denominator;
            end else begin
                resp_next.maximum     = slots_q[req_idx].maximum;
                resp_next.denominator = slots_q[req_idx].denominator;
            end
        end else begin
            resp_next.err = 1'b1;
        end
    end

    always_comb begin
        occ_next = occ_q;
        if (alloc_ok && !free_eff && (occ_q != OCC_W'(N_SLOTS))) begin
            occ_next = occ_q + OCC_W'(1);
        end else if (free_eff && !alloc_ok && (occ_q != '0)) begin
            occ_next = occ_q - OCC_W'(1);
        end
    end

    // Slot storage; only the valid bits are reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                slots_q[i].valid <= 1'b0;
            end
        end else begin
            if (alloc_ok) begin
                slots_q[free_idx] <= slot_t'{valid: 1'b1, maximum: SLOT_NEG_INF_MAX, denominator: '0};
            end
            if (upd_write) begin
                slots_q[upd_idx].maximum     <= upd_op.maximum;
                slots_q[upd_idx].denominator <= upd_op.denominator;
            end
            if (free_eff) begin
                slots_q[upd_idx].valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
            occ_q        <= '0;
            full_q       <= 1'b0;
        end else begin
            if (req_fire) begin
                resp_valid_q <= 1'b1;
                resp_q       <= resp_next;
            end else if (resp_ready_i) begin
                resp_valid_q <= 1'b0;
            end
            occ_q  <= occ_next;
            full_q <= (occ_next == OCC_W'(N_SLOTS));
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_o       = resp_q;
    assign occupancy_o  = occ_q;
    assign full_o       = full_q;

`ifdef SFM_SLOT_CACHE_PERF_EN
    slot_perf_t perf_q;
    logic       alloc_fail;
    logic       load_miss;

    assign alloc_fail = alloc_fire && !free_found;
    assign load_miss  = req_fire && (req_op.op == SLOT_OP_LOAD) && resp_next.err;

    // Saturating event counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else begin
            if (alloc_fire && (perf_q.alloc_cnt != '1)) begin
                perf_q.alloc_cnt <= perf_q.alloc_cnt + PERF_W'(1);
            end
            if (alloc_fail && (perf_q.alloc_fail_cnt != '1)) begin
                perf_q.alloc_fail_cnt <= perf_q.alloc_fail_cnt + PERF_W'(1);
            end
            if (load_miss && (perf_q.load_miss_cnt != '1)) begin
                perf_q.load_miss_cnt <= perf_q.load_miss_cnt + PERF_W'(1);
            end
        end
    end

    assign perf_o = perf_q;
`else
    assign perf_o = '0;
`endif

endmodule

// File: tb/tb_sfm_slot_cache.sv
// Table-driven scoreboard bench for sfm_slot_cache, plus hand sequences for response hold and reset.
module tb_sfm_slot_cache;
    import sfm_pkg::*;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [8:0]   req_op_i;
    logic         upd_valid_i;
    logic [56:0]  upd_op_i;
    logic         resp_valid_o;
    logic         resp_ready_i;
    logic [56:0]  resp_o;
    logic [4:0]   occupancy_o;
    logic         full_o;
    logic [95:0]  perf_o;

    always #5 clk = ~clk;

    sfm_slot_cache dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .upd_valid_i  (upd_valid_i),
        .upd_op_i     (upd_op_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_o       (resp_o),
        .occupancy_o  (occupancy_o),
        .full_o       (full_o),
        .perf_o       (perf_o)
    );

    typedef struct {
        logic        req_v;
        logic        req_op;
        logic [7:0]  req_addr;
        logic        upd_v;
        logic        upd_op;
        logic [7:0]  upd_addr;
        logic [15:0] mx;
        logic [31:0] dn;
        slot_resp_t  exp;
        logic [4:0]  occ;
        logic        full;
    } vec_t;

    localparam int NVEC = 34;
    localparam logic A = 1'b0;   // ALLOC
    localparam logic L = 1'b1;   // LOAD
    localparam logic U = 1'b0;   // UPDATE
    localparam logic F = 1'b1;   // FREE

    vec_t       vecs [NVEC];
    slot_resp_t sb [$];
    slot_resp_t cur_exp;
    slot_perf_t exp_perf;
    int         n_chk  = 0;
    int         n_fail = 0;

    function automatic slot_resp_t rs(input logic [7:0] a, input logic [15:0] m,
                                      input logic [31:0] d, input logic e);
        slot_resp_t r;
        r.addr = a; r.maximum = m; r.denominator = d; r.err = e;
        return r;
    endfunction

    function automatic vec_t mk(input logic rv, input logic ro, input logic [7:0] ra,
                                input logic uv, input logic uo, input logic [7:0] ua,
                                input logic [15:0] m, input logic [31:0] d,
                                input slot_resp_t e, input logic [4:0] o, input logic f);
        vec_t v;
        v.req_v = rv; v.req_op = ro; v.req_addr = ra;
        v.upd_v = uv; v.upd_op = uo; v.upd_addr = ua; v.mx = m; v.dn = d;
        v.exp = e; v.occ = o; v.full = f;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: retire a handshaken response against the scoreboard, record a firing request.
    task automatic tick(input string tag);
        slot_resp_t e;
        @(negedge clk);
        if (resp_valid_o && resp_ready_i) begin
            if (sb.size() == 0) begin
                chk({tag, " unexpected_resp"}, 128'(resp_valid_o), 128'(0));
            end else begin
                e = sb.pop_front();
                chk({tag, " resp"}, 128'(resp_o), 128'(e));
            end
        end
        if (req_valid_i && req_ready_o) sb.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        slot_resp_t held;
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_op_i     = '0;
        upd_valid_i  = 1'b0;
        upd_op_i     = '0;
        resp_ready_i = 1'b1;

        for (int i = 0; i < 16; i++)
            vecs[i] = mk(1, A, 0, 0, U, 0, 0, 0, rs(8'(i), SLOT_NEG_INF_MAX, 0, 0), 5'(i + 1), i == 15);
        vecs[16] = mk(1, A, 0,  0, U, 0,  0, 0, rs(0, 0, 0, 1), 16, 1);
        vecs[17] = mk(0, A, 0,  1, U, 3,  16'h4200, 32'h40800000, rs(0, 0, 0, 0), 16, 1);
        vecs[18] = mk(1, L, 3,  0, U, 0,  0, 0, rs(3, 16'h4200, 32'h40800000, 0), 16, 1);
        vecs[19] = mk(1, L, 3,  1, U, 3,  16'h3F80, 32'h3F800000, rs(3, 16'h3F80, 32'h3F800000, 0), 16, 1);
        vecs[20] = mk(1, L, 3,  0, U, 0,  0, 0, rs(3, 16'h3F80, 32'h3F800000, 0), 16, 1);
        vecs[21] = mk(0, A, 0,  1, F, 5,  0, 0, rs(0, 0, 0, 0), 15, 0);
        vecs[22] = mk(1, A, 0,  0, U, 0,  0, 0, rs(5, SLOT_NEG_INF_MAX, 0, 0), 16, 1);
        vecs[23] = mk(1, A, 0,  1, F, 7,  0, 0, rs(0, 0, 0, 1), 15, 0);
        vecs[24] = mk(1, L, 7,  0, U, 0,  0, 0, rs(7, 0, 0, 1), 15, 0);
        vecs[25] = mk(1, L, 20, 0, U, 0,  0, 0, rs(20, 0, 0, 1), 15, 0);
        vecs[26] = mk(1, L, 2,  1, F, 2,  0, 0, rs(2, 0, 0, 1), 14, 0);
        vecs[27] = mk(1, L, 2,  0, U, 0,  0, 0, rs(2, 0, 0, 1), 14, 0);
        vecs[28] = mk(1, A, 0,  0, U, 0,  0, 0, rs(2, SLOT_NEG_INF_MAX, 0, 0), 15, 0);
        vecs[29] = mk(0, A, 0,  1, U, 7,  16'h1234, 32'h55667788, rs(0, 0, 0, 0), 15, 0);
        vecs[30] = mk(1, A, 0,  0, U, 0,  0, 0, rs(7, SLOT_NEG_INF_MAX, 0, 0), 16, 1);
        vecs[31] = mk(1, L, 7,  0, U, 0,  0, 0, rs(7, SLOT_NEG_INF_MAX, 0, 0), 16, 1);
        vecs[32] = mk(0, A, 0,  1, F, 40, 0, 0, rs(0, 0, 0, 0), 16, 1);
        vecs[33] = mk(1, A, 0,  0, U, 0,  0, 0, rs(0, 0, 0, 1), 16, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("rst resp_valid", 128'(resp_valid_o), 0);
        chk("rst resp",       128'(resp_o), 0);
        chk("rst occupancy",  128'(occupancy_o), 0);
        chk("rst full",       128'(full_o), 0);
        chk("rst perf",       128'(perf_o), 0);
        chk("rst req_ready",  128'(req_ready_o), 1);
        rst_i = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            req_valid_i = vecs[i].req_v;
            req_op_i    = {vecs[i].req_op, vecs[i].req_addr};
            upd_valid_i = vecs[i].upd_v;
            upd_op_i    = {vecs[i].upd_op, vecs[i].upd_addr, vecs[i].mx, vecs[i].dn};
            cur_exp     = vecs[i].exp;
            tick($sformatf("vec%0d", i));
            chk($sformatf("vec%0d occupancy", i), 128'(occupancy_o), 128'(vecs[i].occ));
            chk($sformatf("vec%0d full", i),      128'(full_o),      128'(vecs[i].full));
        end
        req_valid_i = 1'b0;
        upd_valid_i = 1'b0;
        tick("drain");
        chk("scoreboard empty", 128'(sb.size()), 0);

`ifdef SFM_SLOT_CACHE_PERF_EN
        exp_perf = '{alloc_cnt: 32'd22, alloc_fail_cnt: 32'd3, load_miss_cnt: 32'd4};
`else
        exp_perf = '0;
`endif
        chk("perf", 128'(perf_o), 128'(exp_perf));

        // Backpressure: one response held while a second request waits.
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b1;
        req_op_i     = {L, 8'd3};
        cur_exp      = rs(3, 16'h3F80, 32'h3F800000, 0);
        held         = cur_exp;
        tick("hold fire");
        req_op_i     = {L, 8'd4};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d req_ready", k),  128'(req_ready_o), 0);
            chk($sformatf("hold%0d resp_valid", k), 128'(resp_valid_o), 1);
            chk($sformatf("hold%0d resp", k),       128'(resp_o), 128'(held));
            @(posedge clk);
        end
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst resp_valid", 128'(resp_valid_o), 0);
        chk("midrst occupancy",  128'(occupancy_o), 0);
        chk("midrst full",       128'(full_o), 0);
        chk("midrst perf",       128'(perf_o), 0);
        sb.delete();
        rst_i        = 1'b0;
        resp_ready_i = 1'b1;
        req_op_i     = {A, 8'd0};
        cur_exp      = rs(0, SLOT_NEG_INF_MAX, 0, 0);
        tick("post-rst alloc");
        req_valid_i  = 1'b0;
        tick("post-rst drain");
        chk("post-rst occupancy", 128'(occupancy_o), 1);
        chk("post-rst scoreboard empty", 128'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
